reaction_game_key_capture: RTL and testbench
============================================

// Module: reaction_game_key_capture
// PURPOSE
//  Player-input end of the reaction game. The BCD display path drives the player; this block reads the player back.
//  Synchronises and debounces the raw active-low key, then times the press against the game's go event in BCD ms.
//  Emits the 4 result digits (s.cs-style: sec, ds, cs, ms) and disqualify/timeout flags to the top-level FSM/display.
// PARAMETERS
//  DEBOUNCE_MS   5   consecutive tick_ms strobes of stable differing input required to change debounced level (1..15)
//  SYNC_STAGES   2   metastability flops on key_n (>=2)
// PORTS
//  clk           in   1   50 MHz system clock
//  reset         in   1   asynchronous, active-high reset
//  key_n         in   1   raw push-button, active-low, asynchronous to clk
//  tick_ms       in   1   one-cycle strobe every 1 ms (from ms counter chain)
//  start         in   1   one-cycle pulse: begin a round (countdown running)
//  go            in   1   one-cycle pulse: countdown finished, timing begins
//  digits        out  16  {sec,ds,cs,ms} BCD, 4 bits each
//  result_valid  out  1   round finished (DONE or DISQ), level
//  early         out  1   pressed before go ("dis"), level
//  timeout       out  1   no press within 9.999 s, level
//  pressed       out  1   debounced key level (1 = held)
//  best_digits   out  16  only with REACTION_GAME_BEST_TIME_EN
// BEHAVIOUR
//  Reset (async): state IDLE; digits 0; result_valid/early/timeout 0; pressed 0; sync chain loaded with 1 (released).
//  Debounce: sync = last of SYNC_STAGES flops of ~key_n. cnt clears any cycle sync==pressed; else increments on
//   tick_ms; when cnt reaches DEBOUNCE_MS, pressed<=sync, cnt<=0. Releases debounced identically.
//  press_evt: one cycle, asserted in the first cycle pressed reads 1; FSM acts on it at the following edge.
//  Key already held when a round starts never generates press_evt; a fresh release+press is needed.
//  FSM states (typedef in package): IDLE, WAIT, TIMING, DONE, DISQ.
//   IDLE  : start -> WAIT.
//   WAIT  : press_evt -> DISQ (early=1, result_valid=1, digits unchanged 0); else go -> TIMING, digits<=0.
//           press_evt and go same cycle -> DISQ (press wins).
//   TIMING: tick_ms -> BCD increment: ms 0..9 carry cs 0..9 carry ds 0..9 carry sec 0..9.
//           press_evt -> DONE, result_valid=1, digits frozen. press_evt and tick_ms same cycle -> tick ignored.
//           tick_ms with digits==9999 -> DONE, timeout=1, result_valid=1, digits stay 9999 (no wrap).
//   DONE/DISQ: hold outputs; go and press ignored.
//  start in ANY state (incl. mid-TIMING) -> WAIT next edge; digits, result_valid, early, timeout cleared.
//  start takes priority over every other same-cycle event. go outside WAIT is ignored.
//  All outputs registered; no combinational path input->output.
// CONFIGURATION
//  REACTION_GAME_BEST_TIME_EN defined: best_digits register, reset to 9999; on entry to DONE with timeout=0
//   and digits < best_digits (BCD compare = numeric compare), best_digits<=digits. DISQ/timeout never update it.
//   start does not clear it; only reset does.
//  Not defined: best_digits port and register absent; all other behaviour identical.
// STRUCTURE
//  reaction_game_pkg: state enum cap_state_t; typedef bcd4_t (logic [3:0]); typedef bcd_time_t (bcd4_t [3:0]);
//   constants BCD_MAX_TIME = 16'h9999, BCD_ZERO = 16'h0000.
//  Sub-module reaction_game_debounce (sync chain + stability counter; outputs pressed, press_evt).
//  Top holds FSM, BCD counter, optional best-time register.
// TESTING (DEBOUNCE_MS=2, tick_ms every 10 clk in bench)
//  1 Clean press: start, go, 37 ticks, key_n low stable -> DONE, digits 16'h0037+debounce ticks (0039), result_valid=1.
//  2 Early: start, key_n low 3 ticks before go -> DISQ, early=1, digits 0; later go ignored.
//  3 Bounce: key_n toggles every 3 clk for 50 clk in TIMING -> pressed stays 0, no DONE; stable low then -> DONE once.
//  4 Timeout: start, go, no press, 9999 ticks +1 -> timeout=1, digits 16'h9999, result_valid=1.
//  5 Held key: key_n held low through start and go -> no DISQ; release+press -> DONE with correct digits.
//  6 Reset/start mid-TIMING at 16'h0512: start -> WAIT, digits 0, flags 0; async reset mid-cycle -> all outputs 0 at once.
//    With REACTION_GAME_BEST_TIME_EN: rounds 0250, 0180, 0300 -> best_digits 16'h0180.

Source files
------------

// File: rtl/reaction_game_pkg.sv
// Shared types and constants for the reaction game key-capture slice.
// BCD time is {sec, ds, cs, ms}, one nibble per digit, ms in the low nibble.
package reaction_game_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StTiming,
    StDone,
    StDisq
  } cap_state_t;

  typedef logic [3:0] bcd4_t;
  typedef bcd4_t [3:0] bcd_time_t;

  localparam bcd_time_t BCD_MAX_TIME = 16'h9999;
  localparam bcd_time_t BCD_ZERO     = 16'h0000;

  // Width of the debounce stability counter; holds DEBOUNCE_MS up to 15.
  localparam int unsigned DEB_CNT_W = 4;

  // Ripple-carry BCD increment; callers guard against BCD_MAX_TIME.
  function automatic bcd_time_t bcd_inc(input bcd_time_t t);
    bcd_time_t r;
    logic      carry;
    r     = t;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[i] == 4'd9) begin
          r[i] = 4'd0;
        end else begin
          r[i]  = r[i] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/reaction_game_debounce.sv
// Key synchroniser and tick-based debouncer; produces the debounced level and a
// one-cycle press event in the first cycle the debounced level reads 1.
module reaction_game_debounce
  import reaction_game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_MS = 5,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  input  logic tick_ms,
  output logic pressed,
  output logic press_evt
);

  localparam logic [DEB_CNT_W-1:0] CntLast = DEB_CNT_W'(DEBOUNCE_MS - 1);

  // Chain holds raw key_n; reset value 1 means released.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic [DEB_CNT_W-1:0]   cnt_q, cnt_d;
  logic                   pressed_q, pressed_d;
  logic                   pressed_prev_q;

  assign sync = ~sync_q[SYNC_STAGES-1];

  always_comb begin
    cnt_d     = cnt_q;
    pressed_d = pressed_q;
    if (sync == pressed_q) begin
      cnt_d = '0;
    end else if (tick_ms) begin
      if (cnt_q == CntLast) begin
        pressed_d = sync;
        cnt_d     = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q         <= '1;
      cnt_q          <= '0;
      pressed_q      <= 1'b0;
      pressed_prev_q <= 1'b0;
    end else begin
      sync_q         <= {sync_q[SYNC_STAGES-2:0], key_n};
      cnt_q          <= cnt_d;
      pressed_q      <= pressed_d;
      pressed_prev_q <= pressed_q;
    end
  end

  assign pressed   = pressed_q;
  assign press_evt = pressed_q & ~pressed_prev_q;

endmodule

// File: rtl/reaction_game_key_capture.sv
// Reaction game key capture: debounced key timed against go in BCD ms.
// Optional best-time register enabled by defining REACTION_GAME_BEST_TIME_EN.
module reaction_game_key_capture
  import reaction_game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_MS = 5,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        key_n,
  input  logic        tick_ms,
  input  logic        start,
  input  logic        go,
  output logic [15:0] digits,
  output logic        result_valid,
  output logic        early,
  output logic        timeout,
  output logic        pressed
`ifdef REACTION_GAME_BEST_TIME_EN
  ,
  output logic [15:0] best_digits
`endif
);

  logic press_evt;

  reaction_game_debounce #(
    .DEBOUNCE_MS(DEBOUNCE_MS),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_debounce (
    .clk      (clk),
    .reset    (reset),
    .key_n    (key_n),
    .tick_ms  (tick_ms),
    .pressed  (pressed),
    .press_evt(press_evt)
  );

  cap_state_t state_q, state_d;
  bcd_time_t  digits_q, digits_d;
  logic       valid_q, valid_d;
  logic       early_q, early_d;
  logic       timeout_q, timeout_d;
`ifdef REACTION_GAME_BEST_TIME_EN
  bcd_time_t  best_q, best_d;
`endif

  always_comb begin
    state_d   = state_q;
    digits_d  = digits_q;
    valid_d   = valid_q;
    early_d   = early_q;
    timeout_d = timeout_q;
`ifdef REACTION_GAME_BEST_TIME_EN
    best_d    = best_q;
`endif
    // start overrides everything, from any state.
    if (start) begin
      state_d   = StWait;
      digits_d  = BCD_ZERO;
      valid_d   = 1'b0;
      early_d   = 1'b0;
      timeout_d = 1'b0;
    end else begin
      unique case (state_q)
        StWait: begin
          if (press_evt) begin
            state_d = StDisq;
            early_d = 1'b1;
            valid_d = 1'b1;
          end else if (go) begin
            state_d  = StTiming;
            digits_d = BCD_ZERO;
          end
        end
        StTiming: begin
          if (press_evt) begin
            state_d = StDone;
            valid_d = 1'b1;
`ifdef REACTION_GAME_BEST_TIME_EN
            if (digits_q < best_q) begin
              best_d = digits_q;
            end
`endif
          end else if (tick_ms) begin
            if (digits_q == BCD_MAX_TIME) begin
              state_d   = StDone;
              timeout_d = 1'b1;
              valid_d   = 1'b1;
            end else begin
              digits_d = bcd_inc(digits_q);
            end
          end
        end
        StIdle, StDone, StDisq: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      digits_q  <= BCD_ZERO;
      valid_q   <= 1'b0;
      early_q   <= 1'b0;
      timeout_q <= 1'b0;
`ifdef REACTION_GAME_BEST_TIME_EN
      best_q    <= BCD_MAX_TIME;
`endif
    end else begin
      state_q   <= state_d;
      digits_q  <= digits_d;
      valid_q   <= valid_d;
      early_q   <= early_d;
      timeout_q <= timeout_d;
`ifdef REACTION_GAME_BEST_TIME_EN
      best_q    <= best_d;
`endif
    end
  end

  assign digits       = digits_q;
  assign result_valid = valid_q;
  assign early        = early_q;
  assign timeout      = timeout_q;
`ifdef REACTION_GAME_BEST_TIME_EN
  assign best_digits  = best_q;
`endif

endmodule

// File: tb/tb_reaction_game_key_capture.sv
// Self-checking bench for reaction_game_key_capture (DEBOUNCE_MS=2, SYNC_STAGES=2).
module tb_reaction_game_key_capture;

  localparam int unsigned Deb = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        key_n;
  logic        tick_ms;
  logic        start;
  logic        go;
  logic [15:0] digits;
  logic        result_valid;
  logic        early;
  logic        timeout;
  logic        pressed;
`ifdef REACTION_GAME_BEST_TIME_EN
  logic [15:0] best_digits;
  logic [15:0] best_model;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  reaction_game_key_capture #(
    .DEBOUNCE_MS(Deb),
    .SYNC_STAGES(2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .key_n       (key_n),
    .tick_ms     (tick_ms),
    .start       (start),
    .go          (go),
    .digits      (digits),
    .result_valid(result_valid),
    .early       (early),
    .timeout     (timeout),
    .pressed     (pressed)
`ifdef REACTION_GAME_BEST_TIME_EN
    ,
    .best_digits (best_digits)
`endif
  );

  typedef struct {
    string       name;
    int unsigned n_ticks;
    int unsigned gap;
    logic [15:0] exp_digits;
  } press_vec_t;

  press_vec_t vecs[6];

  // Elapsed ms as BCD, straight from decimal arithmetic.
  function automatic logic [15:0] to_bcd(input int unsigned v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_tick(input int gap);
    tick_ms = 1'b1;
    @(negedge clk);
    tick_ms = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_go();
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic tick_until_valid(input int gap, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (result_valid) break;
      pulse_tick(gap);
    end
  endtask

  task automatic release_key();
    key_n = 1'b1;
    idle(3);
    repeat (Deb + 1) pulse_tick(1);
  endtask

  // Start, go, n ticks, then a stable press held until the round ends.
  task automatic press_round(input int n, input int gap);
    pulse_start();
    pulse_go();
    repeat (n) pulse_tick(gap);
    key_n = 1'b0;
    idle(3);
    tick_until_valid(gap, 8);
  endtask

  task automatic expect_done(input string name, input logic [15:0] exp);
    check({name, "_valid"}, {15'd0, result_valid}, 16'd1);
    check({name, "_digits"}, digits, exp);
    check({name, "_early"}, {15'd0, early}, 16'd0);
    check({name, "_timeout"}, {15'd0, timeout}, 16'd0);
`ifdef REACTION_GAME_BEST_TIME_EN
    if (exp < best_model) best_model = exp;
    check({name, "_best"}, best_digits, best_model);
`endif
  endtask

  task automatic expect_disq(input string name);
    check({name, "_valid"}, {15'd0, result_valid}, 16'd1);
    check({name, "_early"}, {15'd0, early}, 16'd1);
    check({name, "_digits"}, digits, 16'h0000);
    check({name, "_timeout"}, {15'd0, timeout}, 16'd0);
`ifdef REACTION_GAME_BEST_TIME_EN
    check({name, "_best"}, best_digits, best_model);
`endif
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got no finish, required finish within 5 ms");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp + 1, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned mode, n, m, gap, g, w;

    vecs[0] = '{"clean_37", 37, 9, 16'h0039};
    vecs[1] = '{"zero", 0, 9, 16'h0002};
    vecs[2] = '{"carry_ms", 8, 3, 16'h0010};
    vecs[3] = '{"carry_cs", 98, 2, 16'h0100};
    vecs[4] = '{"n997", 997, 1, 16'h0999};
    vecs[5] = '{"carry_ds", 998, 1, 16'h1000};

    reset   = 1'b1;
    key_n   = 1'b1;
    tick_ms = 1'b0;
    start   = 1'b0;
    go      = 1'b0;
    idle(3);
    check("rst_digits", digits, 16'h0000);
    check("rst_valid", {15'd0, result_valid}, 16'd0);
    check("rst_early", {15'd0, early}, 16'd0);
    check("rst_timeout", {15'd0, timeout}, 16'd0);
    check("rst_pressed", {15'd0, pressed}, 16'd0);
`ifdef REACTION_GAME_BEST_TIME_EN
    best_model = 16'h9999;
    check("rst_best", best_digits, 16'h9999);
`endif
    reset = 1'b0;
    idle(2);

`ifdef REACTION_GAME_BEST_TIME_EN
    press_round(248, 1);
    expect_done("best_r1", 16'h0250);
    release_key();
    press_round(178, 1);
    expect_done("best_r2", 16'h0180);
    release_key();
    press_round(298, 1);
    expect_done("best_r3", 16'h0300);
    release_key();
    check("best_final", best_digits, 16'h0180);
    pulse_start();
    check("best_kept_by_start", best_digits, 16'h0180);
`endif

    // Table of clean presses.
    for (int i = 0; i < 6; i++) begin
      press_round(vecs[i].n_ticks, vecs[i].gap);
      expect_done(vecs[i].name, vecs[i].exp_digits);
      check({vecs[i].name, "_pressed"}, {15'd0, pressed}, 16'd1);
      release_key();
      check({vecs[i].name, "_released"}, {15'd0, pressed}, 16'd0);
    end

    // Early press, then a late go that must be ignored.
    pulse_start();
    key_n = 1'b0;
    idle(3);
    repeat (3) pulse_tick(9);
    expect_disq("early");
    pulse_go();
    repeat (4) pulse_tick(9);
    expect_disq("early_go_ignored");
    release_key();
    pulse_start();
    check("early_cleared", {14'd0, early, result_valid}, 16'd0);

    // Bouncing key in TIMING must not register.
    pulse_go();
    repeat (20) pulse_tick(9);
    for (int c = 0; c < 50; c++) begin
      key_n   = ((c / 3) % 2 == 0) ? 1'b0 : 1'b1;
      tick_ms = (c % 10 == 0);
      @(negedge clk);
    end
    tick_ms = 1'b0;
    key_n   = 1'b1;
    idle(3);
    check("bounce_pressed", {15'd0, pressed}, 16'd0);
    check("bounce_valid", {15'd0, result_valid}, 16'd0);
    check("bounce_digits", digits, to_bcd(25));
    key_n = 1'b0;
    idle(3);
    tick_until_valid(9, 8);
    expect_done("bounce_done", to_bcd(27));
    release_key();
    key_n = 1'b0;
    idle(3);
    repeat (3) pulse_tick(1);
    check("done_once", digits, to_bcd(27));
    release_key();

    // Key held across start and go.
    key_n = 1'b0;
    idle(3);
    repeat (3) pulse_tick(2);
    pulse_start();
    pulse_go();
    repeat (5) pulse_tick(2);
    check("held_no_disq", {14'd0, early, result_valid}, 16'd0);
    key_n = 1'b1;
    idle(3);
    repeat (2) pulse_tick(2);
    check("held_released", {15'd0, pressed}, 16'd0);
    pulse_tick(2);
    key_n = 1'b0;
    idle(3);
    tick_until_valid(2, 8);
    expect_done("held_done", to_bcd(10));
    release_key();

    // Timeout at 9.999 s with no wrap.
    pulse_start();
    pulse_go();
    repeat (9999) pulse_tick(1);
    check("to_9999", digits, 16'h9999);
    check("to_not_yet", {14'd0, timeout, result_valid}, 16'd0);
    pulse_tick(1);
    check("to_flag", {15'd0, timeout}, 16'd1);
    check("to_valid", {15'd0, result_valid}, 16'd1);
    pulse_tick(1);
    check("to_hold", digits, 16'h9999);
`ifdef REACTION_GAME_BEST_TIME_EN
    check("to_best", best_digits, best_model);
`endif

    // Randomised rounds against the elapsed-ticks model.
    for (int r = 0; r < 16; r++) begin
      mode = $urandom_range(0, 3);
      n    = $urandom_range(0, 120);
      gap  = $urandom_range(1, 4);
      if (mode == 2) begin
        pulse_start();
        key_n = 1'b0;
        idle(3);
        repeat (Deb + 1) pulse_tick(gap);
        pulse_go();
        expect_disq("rnd_early");
      end else if (mode == 3) begin
        pulse_start();
        pulse_go();
        repeat (n) pulse_tick(gap);
        pulse_start();
        check("rnd_abort_digits", digits, 16'h0000);
        check("rnd_abort_valid", {15'd0, result_valid}, 16'd0);
        m = $urandom_range(0, 60);
        pulse_go();
        repeat (m) pulse_tick(gap);
        key_n = 1'b0;
        idle(3);
        tick_until_valid(gap, 8);
        expect_done("rnd_abort", to_bcd(m + Deb));
      end else begin
        g = $urandom_range(0, n);
        w = $urandom_range(1, 4);
        pulse_start();
        pulse_go();
        for (int i = 0; i < int'(n); i++) begin
          pulse_tick(gap);
          if (i == int'(g)) begin
            key_n = 1'b0;
            repeat (w) @(negedge clk);
            key_n = 1'b1;
            idle(3);
          end
        end
        key_n = 1'b0;
        idle(3);
        tick_until_valid(gap, 8);
        expect_done("rnd_press", to_bcd(n + Deb));
      end
      release_key();
    end

    // Restart mid-TIMING, then asynchronous reset mid-cycle.
    pulse_start();
    pulse_go();
    repeat (512) pulse_tick(1);
    check("mid_0512", digits, 16'h0512);
    pulse_start();
    check("mid_start_digits", digits, 16'h0000);
    check("mid_start_flags", {13'd0, early, timeout, result_valid}, 16'd0);
    pulse_go();
    repeat (3) pulse_tick(1);
    check("mid_rewait", digits, 16'h0003);
    key_n = 1'b0;
    idle(3);
    tick_until_valid(1, 8);
    expect_done("mid_done", 16'h0005);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_digits", digits, 16'h0000);
    check("arst_valid", {15'd0, result_valid}, 16'd0);
    check("arst_pressed", {15'd0, pressed}, 16'd0);
    check("arst_flags", {14'd0, early, timeout}, 16'd0);
`ifdef REACTION_GAME_BEST_TIME_EN
    check("arst_best", best_digits, 16'h9999);
`endif
    key_n = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
